hamming_rx_ctrl: RTL and testbench

Receive-side sequencer for the serial Hamming(7,4) decoder on the tt_um top level. It synchronises the raw serial line, detects start bits, and samples seven code bits per frame at mid-bit. Each bit is handed to the decoder as a one-cycle strobe. The block then collects decoded nibbles, pairs them into bytes, and presents each byte on a valid/ready output with frame-error and overrun reporting.

---
 rtl/hamming_rx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_ctrl.sv
// Receive sequencer for the serial Hamming(7,4) link: start-bit detection, mid-bit
// sampling of seven code bits, decoder hand-off, nibble pairing and byte output.
module hamming_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEC_TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_in,
  output logic       bit_out,
  output logic       bit_stb,
  input  logic       dec_valid,
  input  logic [3:0] dec_nibble,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [7:0]  BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] TMO_LAST  = 16'(DEC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_DEC
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [15:0] tmo, tmo_n;
  logic        good, good_n;
  logic        rx_p0, rx_s;
  logic        stb_n, bit_n, ferr_n, cap;
  logic        half;
  logic [3:0]  low;
  logic        done;

  // Next-state and per-cycle control; every decision uses the synchronised line only.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    tmo_n   = tmo;
    good_n  = good;
    stb_n   = 1'b0;
    bit_n   = bit_out;
    ferr_n  = 1'b0;
    cap     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = 8'd0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = 8'd0;
          idx_n   = 3'd0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = 8'd0;
          stb_n = 1'b1;
          bit_n = rx_s;
          if (idx == 3'd6) state_n = S_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = 8'd0;
          tmo_n   = 16'd0;
          good_n  = rx_s;
          ferr_n  = !rx_s;
          state_n = S_WAIT_DEC;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_WAIT_DEC: begin
        // A late dec_valid on the timeout cycle still wins.
        if (dec_valid) begin
          cap     = good;
          state_n = S_IDLE;
        end else if (tmo == TMO_LAST) begin
          ferr_n  = good;
          state_n = S_IDLE;
        end else begin
          tmo_n = tmo + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign done = cap & half;

  // Stage p0/p1: line synchroniser, then FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
      state <= S_IDLE;
      cnt   <= 8'd0;
      idx   <= 3'd0;
      tmo   <= 16'd0;
      good  <= 1'b0;
    end else if (ena) begin
      rx_p0 <= rx_in;
      rx_s  <= rx_p0;
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tmo   <= tmo_n;
      good  <= good_n;
    end
  end

  // Stage p2: registered strobes, nibble pairing and the byte output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_out    <= 1'b0;
      bit_stb    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      half       <= 1'b0;
      low        <= 4'd0;
    end else if (ena) begin
      bit_out   <= bit_n;
      bit_stb   <= stb_n;
      frame_err <= ferr_n;
      overrun   <= 1'b0;
      if (ferr_n) begin
        half <= 1'b0;
      end else if (cap) begin
        if (!half) begin
          low  <= dec_nibble;
          half <= 1'b1;
        end else begin
          half <= 1'b0;
        end
      end
      if (done) begin
        if (byte_valid && !byte_ready) begin
          overrun <= 1'b1;
        end else begin
          byte_data  <= {dec_nibble, low};
          byte_valid <= 1'b1;
        end
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
    end else begin
      bit_stb   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Directed bench for hamming_rx_ctrl: a table of frames plus hand-written
// sequences for glitch, overrun, clock-enable and mid-frame reset.
module tb_hamming_rx_ctrl;
  localparam int C       = 4;
  localparam int D       = 8;
  localparam int DEC_LAT = 6;
  localparam int TAIL    = 14;

  logic       clk = 1'b0;
  logic       rst_n, ena, rx_in;
  logic       bit_out, bit_stb;
  logic       dec_valid, dec_rdy_pulse, rdy_level;
  logic [3:0] dec_nibble;
  logic [7:0] byte_data;
  logic       byte_valid, byte_ready, frame_err, overrun;

  always #5 clk = ~clk;
  assign byte_ready = rdy_level | dec_rdy_pulse;

  hamming_rx_ctrl #(.CLKS_PER_BIT(C), .DEC_TIMEOUT(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx_in(rx_in),
    .bit_out(bit_out), .bit_stb(bit_stb),
    .dec_valid(dec_valid), .dec_nibble(dec_nibble),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: running totals that tests snapshot and difference.
  int         stb_tot = 0, gap_err = 0, ferr_tot = 0, ovr_tot = 0, bv_tot = 0;
  int         last_stb = -100, last_ferr = 0;
  logic [6:0] bits_sr = 7'd0;
  logic [7:0] last_bv = 8'd0;
  always @(negedge clk) begin
    if (bit_stb) begin
      if ((cyc - last_stb) < 2 * C && (cyc - last_stb) != C) gap_err <= gap_err + 1;
      last_stb <= cyc;
      stb_tot  <= stb_tot + 1;
      bits_sr  <= {bit_out, bits_sr[6:1]};
    end
    if (frame_err) begin
      ferr_tot  <= ferr_tot + 1;
      last_ferr <= cyc;
    end
    if (overrun) ovr_tot <= ovr_tot + 1;
    if (byte_valid) begin
      bv_tot  <= bv_tot + 1;
      last_bv <= byte_data;
    end
  end

  // Decoder model: answers DEC_LAT cycles after the seventh strobe.
  logic [3:0] dec_val;
  logic       dec_hold, dec_rdy;
  int         dec_bits, dec_cd;
  always @(negedge clk) begin
    dec_valid     <= 1'b0;
    dec_rdy_pulse <= 1'b0;
    if (!rst_n) begin
      dec_bits   <= 0;
      dec_cd     <= 0;
      dec_nibble <= 4'd0;
    end else begin
      if (dec_cd == 1 && !dec_hold) begin
        dec_valid     <= 1'b1;
        dec_nibble    <= dec_val;
        dec_rdy_pulse <= dec_rdy;
      end
      if (bit_stb && dec_bits == 6) begin
        dec_bits <= 0;
        dec_cd   <= DEC_LAT;
      end else begin
        if (bit_stb) dec_bits <= dec_bits + 1;
        if (dec_cd > 0) dec_cd <= dec_cd - 1;
      end
    end
  end

  int nerr = 0, nchk = 0;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ham(input logic [3:0] n);
    logic p1, p2, p3;
    p1 = n[0] ^ n[1] ^ n[3];
    p2 = n[0] ^ n[2] ^ n[3];
    p3 = n[1] ^ n[2] ^ n[3];
    return {n[3], n[2], n[1], p3, n[0], p2, p1};
  endfunction

  task automatic bit_period(input logic v);
    rx_in = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] nib, input logic stop, input logic hold,
                           input logic rdy_at_dec);
    logic [6:0] code;
    code     = ham(nib);
    dec_val  = nib;
    dec_hold = hold;
    dec_rdy  = rdy_at_dec;
    bit_period(1'b0);
    for (int i = 0; i < 7; i++) bit_period(code[i]);
    bit_period(stop);
    rx_in = 1'b1;
    repeat (TAIL) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [3:0] nib;
    logic       stop;
    logic       hold;
    int         ferr;
    int         ferr_dly;
    int         bv;
    logic [7:0] byte_exp;
  } vec_t;

  vec_t vt[10];
  int   s_stb, s_gap, s_ferr, s_bv, s_ovr;

  initial begin
    vt[0] = '{"good5",   4'h5, 1'b1, 1'b0, 0, 0,     0, 8'h00};
    vt[1] = '{"goodA",   4'hA, 1'b1, 1'b0, 0, 0,     1, 8'hA5};
    vt[2] = '{"good1",   4'h1, 1'b1, 1'b0, 0, 0,     0, 8'h00};
    vt[3] = '{"badstop", 4'h7, 1'b0, 1'b0, 1, C,     0, 8'h00};
    vt[4] = '{"good3",   4'h3, 1'b1, 1'b0, 0, 0,     0, 8'h00};
    vt[5] = '{"goodC",   4'hC, 1'b1, 1'b0, 0, 0,     1, 8'hC3};
    vt[6] = '{"good2",   4'h2, 1'b1, 1'b0, 0, 0,     0, 8'h00};
    vt[7] = '{"timeout", 4'h9, 1'b1, 1'b1, 1, C + D, 0, 8'h00};
    vt[8] = '{"good6",   4'h6, 1'b1, 1'b0, 0, 0,     0, 8'h00};
    vt[9] = '{"goodE",   4'hE, 1'b1, 1'b0, 0, 0,     1, 8'hE6};

    rst_n = 1'b0; ena = 1'b1; rx_in = 1'b1; rdy_level = 1'b1;
    dec_val = 4'h0; dec_hold = 1'b0; dec_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/bit_stb", bit_stb, 0);
    chk("rst/byte_valid", byte_valid, 0);
    chk("rst/byte_data", byte_data, 0);
    chk("rst/frame_err", frame_err, 0);
    chk("rst/overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Glitch: one low cycle must never leave START for DATA.
    s_stb = stb_tot; s_ferr = ferr_tot;
    rx_in = 1'b0;
    @(posedge clk); #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch/stb", stb_tot - s_stb, 0);
    chk("glitch/ferr", ferr_tot - s_ferr, 0);

    for (int i = 0; i < 10; i++) begin
      s_stb = stb_tot; s_gap = gap_err; s_ferr = ferr_tot; s_bv = bv_tot;
      run_frame(vt[i].nib, vt[i].stop, vt[i].hold, 1'b0);
      chk({vt[i].name, "/stb"}, stb_tot - s_stb, 7);
      chk({vt[i].name, "/bits"}, int'(bits_sr), int'(ham(vt[i].nib)));
      chk({vt[i].name, "/gap"}, gap_err - s_gap, 0);
      chk({vt[i].name, "/ferr"}, ferr_tot - s_ferr, vt[i].ferr);
      if (vt[i].ferr_dly != 0) chk({vt[i].name, "/ferr_dly"}, last_ferr - last_stb, vt[i].ferr_dly);
      chk({vt[i].name, "/bv_cycles"}, bv_tot - s_bv, vt[i].bv);
      if (vt[i].bv != 0) chk({vt[i].name, "/byte"}, int'(last_bv), int'(vt[i].byte_exp));
    end

    // Overrun: 0x21 pending, 0x43 completes with ready low.
    rdy_level = 1'b0;
    s_ovr = ovr_tot;
    run_frame(4'h1, 1'b1, 1'b0, 1'b0);
    run_frame(4'h2, 1'b1, 1'b0, 1'b0);
    chk("pend/byte_valid", byte_valid, 1);
    chk("pend/byte_data", byte_data, 8'h21);
    run_frame(4'h3, 1'b1, 1'b0, 1'b0);
    run_frame(4'h4, 1'b1, 1'b0, 1'b0);
    chk("ovr/count", ovr_tot - s_ovr, 1);
    chk("ovr/byte_data", byte_data, 8'h21);
    chk("ovr/byte_valid", byte_valid, 1);

    // Handshake in the completion cycle: new byte loads, no overrun.
    s_ovr = ovr_tot;
    run_frame(4'h3, 1'b1, 1'b0, 1'b0);
    run_frame(4'h4, 1'b1, 1'b0, 1'b1);
    chk("simul/overrun", ovr_tot - s_ovr, 0);
    chk("simul/byte_data", byte_data, 8'h43);
    chk("simul/byte_valid", byte_valid, 1);

    // Mid-frame reset with a low nibble stored and a byte pending.
    run_frame(4'h5, 1'b1, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("prerst/bit_out", bit_out, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst/bit_out", bit_out, 0);
    chk("midrst/bit_stb", bit_stb, 0);
    chk("midrst/byte_valid", byte_valid, 0);
    chk("midrst/byte_data", byte_data, 0);
    chk("midrst/frame_err", frame_err, 0);
    chk("midrst/overrun", overrun, 0);
    rst_n = 1'b1;
    rdy_level = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_bv = bv_tot; s_stb = stb_tot;
    run_frame(4'h8, 1'b1, 1'b0, 1'b0);
    run_frame(4'h9, 1'b1, 1'b0, 1'b0);
    chk("postrst/stb", stb_tot - s_stb, 14);
    chk("postrst/bv_cycles", bv_tot - s_bv, 1);
    chk("postrst/byte", last_bv, 8'h98);

    // Clock enable low: byte_valid holds despite byte_ready.
    rdy_level = 1'b0;
    run_frame(4'hA, 1'b1, 1'b0, 1'b0);
    run_frame(4'hB, 1'b1, 1'b0, 1'b0);
    chk("ena/pend_data", byte_data, 8'hBA);
    ena = 1'b0;
    rdy_level = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ena/hold_valid", byte_valid, 1);
    ena = 1'b1;
    @(posedge clk); #1;
    chk("ena/consumed", byte_valid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
